rename_stage: RTL and testbench
===============================

# rename_stage

Two-wide register-rename stage between decode and dispatch. Accepts up to two decoded instructions per cycle, maps architectural sources through the speculative RAT, and allocates physical destinations from a bitvector free list. Assigns ROB ids and presents a registered pair to dispatch as `rename_valid` / `rename_instruction_0/1` / `rob_id_0/1`, together with a busy mask that clears `PRF_valid`. Retirement updates a committed RAT and a committed free list; flush restores both.

## Interface
- `ARCH_REGS`, 32, architectural registers.
- `PHY_REGS`, 64, physical registers.
- `PHY_WIDTH`, 6, physical tag width.
- `ROB_WIDTH`, 4, ROB id width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `decode_valid` in 2: per-slot valid.
- `decode_instruction_0/1` in `instruction_t`: uses `opcode`, `rd`, `rs1`, `rs2`.
- `rename_ready` out 1: combinational; this cycle's decode pair will be accepted.
- `rob_free_slots` in ROB_WIDTH+1: free ROB entries.
- `commit_valid` in 2: retire slots.
- `commit_rd_0/1` in 5, `commit_prd_0/1` in PHY_WIDTH, `commit_old_prd_0/1` in PHY_WIDTH.
- `flush` in 1: mispredict recovery.
- `flush_rob_tail` in ROB_WIDTH: ROB id restart point.
- `rename_valid` out 2.
- `rename_instruction_0/1` out `instruction_t`: input fields plus `prd`, `prs1`, `prs2`, `old_prd`.
- `rob_id_0/1` out ROB_WIDTH.
- `prf_busy_set` out PHY_REGS: one-cycle mask of newly allocated tags.

## Operation
- **State**
  - `rat[ARCH_REGS]`, `rrat[ARCH_REGS]`.
  - `free_vec`, `committed_free_vec` (PHY_REGS bits, 1 = free).
  - `rob_tail` (ROB_WIDTH bits, wraps modulo 2^ROB_WIDTH).
- **Reset**
  - `rat[i]` = `rrat[i]` = i.
  - Free and committed-free bits set for 32..63, clear for 0..31.
  - `rob_tail` = 0; all outputs 0.
- **Ready rule:** `rename_ready` = popcount(`free_vec`) ≥ 2 AND `rob_free_slots` ≥ 2 AND !`flush`.
- **Acceptance:** all-or-nothing per pair.
  - Legal `decode_valid`: 00, 01, 11.
  - 10 is dropped: no allocation, `rename_valid` = 00.
- **Allocation**
  - Slot 0 takes the lowest set bit of `free_vec`; slot 1 takes the next-lowest.
  - Tag 0 is never allocated.
  - A slot allocates only if valid and `rd` != 0. With `rd` = 0: `prd` = 0, `old_prd` = 0, no `prf_busy_set` bit.
- **Source mapping:** `prs` = `rat[rs]`, with intra-pair bypass. Slot 1 `rs1`/`rs2` equal to slot 0 `rd` (nonzero) take slot 0's new `prd`.
- **old_prd:** equals `rat[rd]`. If both slots write the same `rd`, slot 1 `old_prd` = slot 0 `prd` and the RAT keeps slot 1's `prd`.
- **ROB ids:** `rob_id_0` = `rob_tail`, `rob_id_1` = `rob_tail`+1. Tail advances by the number of accepted valid slots.
- **Commit (per valid slot, slot 0 then slot 1)**
  - `rrat[commit_rd]` ← `commit_prd`; clear `committed_free_vec[commit_prd]`.
  - Set `committed_free_vec[commit_old_prd]` and `free_vec[commit_old_prd]`.
  - Skipped when `commit_rd` = 0.
- **Flush**
  - `rat` ← `rrat`, `free_vec` ← `committed_free_vec`, `rob_tail` ← `flush_rob_tail`.
  - Both copies include same-cycle commit updates. Decode inputs are ignored; outputs are 0 next cycle.

## Timing
- Latency: 1 cycle. Pair accepted at edge N → outputs valid after edge N for one cycle.
- Outputs hold 0 when nothing is accepted.
- No downstream backpressure. Decode holds its pair while `rename_ready` = 0.
- Tags freed by commit at edge N are allocatable for the pair accepted at edge N+1 or later.
- Allocation and commit freeing the same tag in one cycle cannot occur; the tag is busy until freed.
- Reset asserted mid-operation returns all state to reset values immediately.

## Test plan
- **Reset:** all outputs 0, `rename_ready` = 1 with `rob_free_slots` = 16.
- **Dependent pair after reset:** `add x5,x1,x2` ; `add x6,x5,x3` →
  - slot 0: `prd` 32, `prs1` 1, `prs2` 2, `old_prd` 5, `rob_id_0` 0.
  - slot 1: `prd` 33, `prs1` 32, `prs2` 3, `old_prd` 6, `rob_id_1` 1.
  - `prf_busy_set` bits 32, 33.
- **WAW and x0:** `addi x7`, `addi x7` → slot 1 `old_prd` = slot 0 `prd`, RAT[7] = slot 1 `prd`. `rd` = x0 → `prd` 0, no busy bit, no allocation.
- **Free-list exhaustion:** 16 pairs allocate tags 32..63; `rename_ready` then drops to 0. One two-slot commit frees 2 tags → ready the next cycle, and those tags are reallocated.
- **Flush:** after 3 speculative pairs, `flush` with `flush_rob_tail` = 4 → RAT equals RRAT, next allocation restarts at the lowest committed-free tag, next `rob_id_0` = 4.
- **Edge cases:** commit and flush in the same cycle → restored state includes the commit. `decode_valid` = 10 → no outputs, no allocation. ROB tail at 15 with pair → ids 15 and 0.

Source files
------------

// File: rtl/rename_stage_if.sv
// Shared types and the decode/commit/dispatch port bundle for the rename stage.
// The package holds the instruction payload so both the stage and its users agree on layout.
package rename_stage_pkg;
  localparam int unsigned ARCH_REGS  = 32;
  localparam int unsigned AREG_WIDTH = 5;
  localparam int unsigned PHY_REGS   = 64;
  localparam int unsigned PHY_WIDTH  = 6;
  localparam int unsigned ROB_WIDTH  = 4;
  localparam int unsigned OPC_WIDTH  = 7;

  typedef struct packed {
    logic [OPC_WIDTH-1:0]  opcode;
    logic [AREG_WIDTH-1:0] rd;
    logic [AREG_WIDTH-1:0] rs1;
    logic [AREG_WIDTH-1:0] rs2;
    logic [PHY_WIDTH-1:0]  prd;
    logic [PHY_WIDTH-1:0]  prs1;
    logic [PHY_WIDTH-1:0]  prs2;
    logic [PHY_WIDTH-1:0]  old_prd;
  } instruction_t;
endpackage

interface rename_stage_if;
  import rename_stage_pkg::*;

  logic [1:0]            decode_valid;
  instruction_t          decode_instruction_0;
  instruction_t          decode_instruction_1;
  logic                  rename_ready;
  logic [ROB_WIDTH:0]    rob_free_slots;
  logic [1:0]            commit_valid;
  logic [AREG_WIDTH-1:0] commit_rd_0;
  logic [AREG_WIDTH-1:0] commit_rd_1;
  logic [PHY_WIDTH-1:0]  commit_prd_0;
  logic [PHY_WIDTH-1:0]  commit_prd_1;
  logic [PHY_WIDTH-1:0]  commit_old_prd_0;
  logic [PHY_WIDTH-1:0]  commit_old_prd_1;
  logic                  flush;
  logic [ROB_WIDTH-1:0]  flush_rob_tail;
  logic [1:0]            rename_valid;
  instruction_t          rename_instruction_0;
  instruction_t          rename_instruction_1;
  logic [ROB_WIDTH-1:0]  rob_id_0;
  logic [ROB_WIDTH-1:0]  rob_id_1;
  logic [PHY_REGS-1:0]   prf_busy_set;

  modport master (
    output decode_valid, decode_instruction_0, decode_instruction_1, rob_free_slots,
           commit_valid, commit_rd_0, commit_rd_1, commit_prd_0, commit_prd_1,
           commit_old_prd_0, commit_old_prd_1, flush, flush_rob_tail,
    input  rename_ready, rename_valid, rename_instruction_0, rename_instruction_1,
           rob_id_0, rob_id_1, prf_busy_set
  );

  modport slave (
    input  decode_valid, decode_instruction_0, decode_instruction_1, rob_free_slots,
           commit_valid, commit_rd_0, commit_rd_1, commit_prd_0, commit_prd_1,
           commit_old_prd_0, commit_old_prd_1, flush, flush_rob_tail,
    output rename_ready, rename_valid, rename_instruction_0, rename_instruction_1,
           rob_id_0, rob_id_1, prf_busy_set
  );
endinterface

// File: rtl/rename_stage.sv
// Two-wide rename: speculative/committed RAT pair, bitvector free lists, ROB id assignment.
// One-cycle registered output toward dispatch; flush restores the committed copies.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  rename_stage_if.slave rn
);

  localparam int unsigned CNT_WIDTH  = PHY_WIDTH + 1;
  localparam int unsigned SLOT_WIDTH = ROB_WIDTH + 1;

  logic [PHY_WIDTH-1:0] rat_q  [ARCH_REGS];
  logic [PHY_WIDTH-1:0] rat_d  [ARCH_REGS];
  logic [PHY_WIDTH-1:0] rrat_q [ARCH_REGS];
  logic [PHY_WIDTH-1:0] rrat_d [ARCH_REGS];
  logic [PHY_REGS-1:0]  free_q, free_d, cfree_q, cfree_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;

  logic [1:0]           valid_q, valid_d;
  instruction_t         inst0_q, inst0_d, inst1_q, inst1_d;
  logic [ROB_WIDTH-1:0] rob0_q, rob0_d, rob1_q, rob1_d;
  logic [PHY_REGS-1:0]  busy_q, busy_d;

  logic [CNT_WIDTH-1:0] free_cnt;
  logic                 ready, fire, v0, v1, alloc0, alloc1;
  logic [PHY_REGS-1:0]  free_wo_a;
  logic [PHY_WIDTH-1:0] tag_a, tag_b;
  logic [PHY_WIDTH-1:0] prd0, prs1_0, prs2_0, old0;
  logic [PHY_WIDTH-1:0] prd1, prs1_1, prs2_1, old1;
  instruction_t         d0, d1;

  // Lowest free tag above 0; tag 0 is permanently reserved for x0.
  function automatic logic [PHY_WIDTH-1:0] lowest_free(input logic [PHY_REGS-1:0] v);
    logic [PHY_WIDTH-1:0] r;
    r = '0;
    for (int i = int'(PHY_REGS) - 1; i >= 1; i--) begin
      if (v[i]) r = PHY_WIDTH'(i);
    end
    return r;
  endfunction

  // Readiness and allocation decisions for the current decode pair.
  always_comb begin
    free_cnt = '0;
    for (int i = 1; i < int'(PHY_REGS); i++) begin
      free_cnt = free_cnt + CNT_WIDTH'(free_q[i]);
    end
    ready = (free_cnt >= CNT_WIDTH'(2)) && (rn.rob_free_slots >= SLOT_WIDTH'(2)) && !rn.flush;
    d0    = rn.decode_instruction_0;
    d1    = rn.decode_instruction_1;
    v0    = rn.decode_valid[0];
    v1    = rn.decode_valid[1];
    fire  = ready && v0;
    alloc0 = fire && (d0.rd != '0);
    alloc1 = fire && v1 && (d1.rd != '0);

    tag_a = lowest_free(free_q);
    free_wo_a = free_q;
    free_wo_a[tag_a] = 1'b0;
    tag_b = lowest_free(free_wo_a);

    prd0 = alloc0 ? tag_a : '0;
    prd1 = '0;
    if (alloc1) prd1 = alloc0 ? tag_b : tag_a;

    prs1_0 = rat_q[d0.rs1];
    prs2_0 = rat_q[d0.rs2];
    old0   = alloc0 ? rat_q[d0.rd] : '0;

    // Slot 1 sees slot 0's fresh mapping inside the pair.
    prs1_1 = (alloc0 && d1.rs1 == d0.rd) ? prd0 : rat_q[d1.rs1];
    prs2_1 = (alloc0 && d1.rs2 == d0.rd) ? prd0 : rat_q[d1.rs2];
    old1   = '0;
    if (alloc1) old1 = (alloc0 && d1.rd == d0.rd) ? prd0 : rat_q[d1.rd];
  end

  // Next-state for tables, free lists, ROB tail and the dispatch register.
  always_comb begin
    rat_d   = rat_q;
    rrat_d  = rrat_q;
    free_d  = free_q;
    cfree_d = cfree_q;
    tail_d  = tail_q;
    valid_d = '0;
    inst0_d = '0;
    inst1_d = '0;
    rob0_d  = '0;
    rob1_d  = '0;
    busy_d  = '0;

    if (rn.commit_valid[0] && rn.commit_rd_0 != '0) begin
      rrat_d[rn.commit_rd_0]      = rn.commit_prd_0;
      cfree_d[rn.commit_prd_0]    = 1'b0;
      cfree_d[rn.commit_old_prd_0] = 1'b1;
      free_d[rn.commit_old_prd_0]  = 1'b1;
    end
    if (rn.commit_valid[1] && rn.commit_rd_1 != '0) begin
      rrat_d[rn.commit_rd_1]      = rn.commit_prd_1;
      cfree_d[rn.commit_prd_1]    = 1'b0;
      cfree_d[rn.commit_old_prd_1] = 1'b1;
      free_d[rn.commit_old_prd_1]  = 1'b1;
    end

    if (rn.flush) begin
      rat_d  = rrat_d;
      free_d = cfree_d;
      tail_d = rn.flush_rob_tail;
    end else if (fire) begin
      valid_d = {v1, 1'b1};
      tail_d  = tail_q + ROB_WIDTH'(1) + ROB_WIDTH'(v1);

      inst0_d         = d0;
      inst0_d.prd     = prd0;
      inst0_d.prs1    = prs1_0;
      inst0_d.prs2    = prs2_0;
      inst0_d.old_prd = old0;
      rob0_d          = tail_q;
      if (alloc0) begin
        free_d[prd0]     = 1'b0;
        busy_d[prd0]     = 1'b1;
        rat_d[d0.rd]     = prd0;
      end

      if (v1) begin
        inst1_d         = d1;
        inst1_d.prd     = prd1;
        inst1_d.prs1    = prs1_1;
        inst1_d.prs2    = prs2_1;
        inst1_d.old_prd = old1;
        rob1_d          = tail_q + ROB_WIDTH'(1);
      end
      if (alloc1) begin
        free_d[prd1]     = 1'b0;
        busy_d[prd1]     = 1'b1;
        rat_d[d1.rd]     = prd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) begin
        rat_q[i]  <= PHY_WIDTH'(i);
        rrat_q[i] <= PHY_WIDTH'(i);
      end
      free_q  <= {{(PHY_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
      cfree_q <= {{(PHY_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
      tail_q  <= '0;
      valid_q <= '0;
      inst0_q <= '0;
      inst1_q <= '0;
      rob0_q  <= '0;
      rob1_q  <= '0;
      busy_q  <= '0;
    end else begin
      rat_q   <= rat_d;
      rrat_q  <= rrat_d;
      free_q  <= free_d;
      cfree_q <= cfree_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      rob0_q  <= rob0_d;
      rob1_q  <= rob1_d;
      busy_q  <= busy_d;
    end
  end

  assign rn.rename_ready         = ready;
  assign rn.rename_valid         = valid_q;
  assign rn.rename_instruction_0 = inst0_q;
  assign rn.rename_instruction_1 = inst1_q;
  assign rn.rob_id_0             = rob0_q;
  assign rn.rob_id_1             = rob1_q;
  assign rn.prf_busy_set         = busy_q;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: vector table for single pairs plus flush/exhaustion sequences.
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_stage_if bus ();
  rename_stage u_dut (.clk(clk), .rst(rst), .rn(bus));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int dv;
    int rd0, rs10, rs20, rd1, rs11, rs21;
    int ev;
    int prd0, prs10, prs20, old0;
    int prd1, prs11, prs21, old1;
    int rob0, rob1;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int dv, input int rd0, input int rs10, input int rs20,
                       input int rd1, input int rs11, input int rs21);
    instruction_t t0, t1;
    t0 = '0; t1 = '0;
    t0.opcode = 7'h33; t0.rd = 5'(rd0); t0.rs1 = 5'(rs10); t0.rs2 = 5'(rs20);
    t1.opcode = 7'h33; t1.rd = 5'(rd1); t1.rs1 = 5'(rs11); t1.rs2 = 5'(rs21);
    bus.decode_valid = 2'(dv);
    bus.decode_instruction_0 = t0;
    bus.decode_instruction_1 = t1;
  endtask

  task automatic clear_side();
    bus.commit_valid = '0; bus.flush = 1'b0; bus.flush_rob_tail = '0;
    bus.commit_rd_0 = '0; bus.commit_prd_0 = '0; bus.commit_old_prd_0 = '0;
    bus.commit_rd_1 = '0; bus.commit_prd_1 = '0; bus.commit_old_prd_1 = '0;
  endtask

  task automatic chk_slot(input string name, input instruction_t a,
                          input int prd, input int prs1, input int prs2, input int old);
    chk({name, ".prd"},     64'(a.prd),     64'(prd));
    chk({name, ".prs1"},    64'(a.prs1),    64'(prs1));
    chk({name, ".prs2"},    64'(a.prs2),    64'(prs2));
    chk({name, ".old_prd"}, 64'(a.old_prd), 64'(old));
  endtask

  initial begin
    logic [63:0] exp_busy;

    vt[0] = '{dv:3, rd0:5, rs10:1, rs20:2, rd1:6, rs11:5, rs21:3, ev:3,
              prd0:32, prs10:1, prs20:2, old0:5, prd1:33, prs11:32, prs21:3, old1:6, rob0:0, rob1:1};
    vt[1] = '{dv:3, rd0:7, rs10:7, rs20:0, rd1:7, rs11:7, rs21:0, ev:3,
              prd0:34, prs10:7, prs20:0, old0:7, prd1:35, prs11:34, prs21:0, old1:34, rob0:2, rob1:3};
    vt[2] = '{dv:3, rd0:8, rs10:7, rs20:5, rd1:0, rs11:8, rs21:6, ev:3,
              prd0:36, prs10:35, prs20:32, old0:8, prd1:0, prs11:36, prs21:33, old1:0, rob0:4, rob1:5};
    vt[3] = '{dv:2, rd0:9, rs10:8, rs20:7, rd1:9, rs11:1, rs21:1, ev:0,
              prd0:0, prs10:0, prs20:0, old0:0, prd1:0, prs11:0, prs21:0, old1:0, rob0:0, rob1:0};
    vt[4] = '{dv:1, rd0:9, rs10:8, rs20:7, rd1:0, rs11:0, rs21:0, ev:1,
              prd0:37, prs10:36, prs20:35, old0:9, prd1:0, prs11:0, prs21:0, old1:0, rob0:6, rob1:0};

    drive(0, 0, 0, 0, 0, 0, 0);
    clear_side();
    bus.rob_free_slots = 5'd16;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    chk("reset.valid", 64'(bus.rename_valid), 64'd0);
    chk("reset.busy",  bus.prf_busy_set, 64'd0);
    chk("reset.inst0", 64'(bus.rename_instruction_0), 64'd0);
    chk("reset.ready", 64'(bus.rename_ready), 64'd1);

    // Table: single pairs with intra-pair bypass, WAW, x0, dropped 10 and lone slot 0.
    for (int i = 0; i < 5; i++) begin
      drive(vt[i].dv, vt[i].rd0, vt[i].rs10, vt[i].rs20, vt[i].rd1, vt[i].rs11, vt[i].rs21);
      #1;
      chk($sformatf("v%0d.ready", i), 64'(bus.rename_ready), 64'd1);
      cycle();
      chk($sformatf("v%0d.valid", i), 64'(bus.rename_valid), 64'(vt[i].ev));
      chk_slot($sformatf("v%0d.s0", i), bus.rename_instruction_0,
               vt[i].prd0, vt[i].prs10, vt[i].prs20, vt[i].old0);
      chk($sformatf("v%0d.rob0", i), 64'(bus.rob_id_0), 64'(vt[i].rob0));
      if (vt[i].ev == 3 || vt[i].dv == 2) begin
        chk_slot($sformatf("v%0d.s1", i), bus.rename_instruction_1,
                 vt[i].prd1, vt[i].prs11, vt[i].prs21, vt[i].old1);
        chk($sformatf("v%0d.rob1", i), 64'(bus.rob_id_1), 64'(vt[i].rob1));
      end
      if (vt[i].ev != 0)
        chk($sformatf("v%0d.rd", i), 64'(bus.rename_instruction_0.rd), 64'(vt[i].rd0));
      exp_busy = '0;
      if ((vt[i].ev & 1) != 0 && vt[i].prd0 != 0) exp_busy[vt[i].prd0] = 1'b1;
      if ((vt[i].ev & 2) != 0 && vt[i].prd1 != 0) exp_busy[vt[i].prd1] = 1'b1;
      chk($sformatf("v%0d.busy", i), bus.prf_busy_set, exp_busy);
    end

    // Commit of x5 (prd 32, old 5) in the same cycle as a flush to tail 4.
    drive(3, 20, 1, 1, 21, 1, 1);
    bus.commit_valid = 2'b01; bus.commit_rd_0 = 5'd5;
    bus.commit_prd_0 = 6'd32; bus.commit_old_prd_0 = 6'd5;
    bus.flush = 1'b1; bus.flush_rob_tail = 4'd4;
    #1;
    chk("flush.ready", 64'(bus.rename_ready), 64'd0);
    cycle();
    clear_side();
    chk("flush.valid", 64'(bus.rename_valid), 64'd0);
    chk("flush.busy",  bus.prf_busy_set, 64'd0);
    drive(3, 11, 5, 0, 12, 11, 6);
    cycle();
    chk("postflush.valid", 64'(bus.rename_valid), 64'd3);
    chk_slot("postflush.s0", bus.rename_instruction_0, 5, 32, 0, 11);
    chk_slot("postflush.s1", bus.rename_instruction_1, 33, 5, 6, 12);
    chk("postflush.rob0", 64'(bus.rob_id_0), 64'd4);
    chk("postflush.rob1", 64'(bus.rob_id_1), 64'd5);

    // Flush to tail 15, then a pair wraps the ROB id.
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b1; bus.flush_rob_tail = 4'd15;
    cycle();
    clear_side();
    drive(3, 1, 5, 11, 2, 1, 12);
    cycle();
    chk_slot("wrap.s0", bus.rename_instruction_0, 5, 32, 11, 1);
    chk_slot("wrap.s1", bus.rename_instruction_1, 33, 5, 12, 2);
    chk("wrap.rob0", 64'(bus.rob_id_0), 64'd15);
    chk("wrap.rob1", 64'(bus.rob_id_1), 64'd0);

    drive(0, 0, 0, 0, 0, 0, 0);
    bus.rob_free_slots = 5'd1;
    #1;
    chk("robfull.ready", 64'(bus.rename_ready), 64'd0);
    bus.rob_free_slots = 5'd16;

    // Asynchronous reset mid-operation clears the output register at once.
    rst = 1'b1;
    #1;
    chk("midrst.valid", 64'(bus.rename_valid), 64'd0);
    chk("midrst.busy",  bus.prf_busy_set, 64'd0);
    cycle();
    rst = 1'b0;

    // Exhaust tags 32..63 with 16 pairs writing x1, x2.
    for (int k = 0; k < 16; k++) begin
      drive(3, 1, 3, 4, 2, 1, 0);
      #1;
      chk($sformatf("ex%0d.ready", k), 64'(bus.rename_ready), 64'd1);
      cycle();
      chk_slot($sformatf("ex%0d.s0", k), bus.rename_instruction_0,
               32 + 2*k, 3, 4, (k == 0) ? 1 : 32 + 2*(k-1));
      chk_slot($sformatf("ex%0d.s1", k), bus.rename_instruction_1,
               33 + 2*k, 32 + 2*k, 0, (k == 0) ? 2 : 33 + 2*(k-1));
      chk($sformatf("ex%0d.rob0", k), 64'(bus.rob_id_0), 64'((2*k) % 16));
      chk($sformatf("ex%0d.rob1", k), 64'(bus.rob_id_1), 64'((2*k + 1) % 16));
    end
    drive(3, 3, 0, 0, 4, 0, 0);
    bus.commit_valid = 2'b11;
    bus.commit_rd_0 = 5'd1; bus.commit_prd_0 = 6'd32; bus.commit_old_prd_0 = 6'd1;
    bus.commit_rd_1 = 5'd2; bus.commit_prd_1 = 6'd33; bus.commit_old_prd_1 = 6'd2;
    #1;
    chk("empty.ready", 64'(bus.rename_ready), 64'd0);
    cycle();
    clear_side();
    chk("empty.valid", 64'(bus.rename_valid), 64'd0);
    chk("refill.ready", 64'(bus.rename_ready), 64'd1);
    cycle();
    chk("refill.valid", 64'(bus.rename_valid), 64'd3);
    chk_slot("refill.s0", bus.rename_instruction_0, 1, 0, 0, 3);
    chk_slot("refill.s1", bus.rename_instruction_1, 2, 0, 0, 4);
    exp_busy = '0; exp_busy[1] = 1'b1; exp_busy[2] = 1'b1;
    chk("refill.busy", bus.prf_busy_set, exp_busy);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drained.ready", 64'(bus.rename_ready), 64'd0);
    cycle();
    chk("idle.valid", 64'(bus.rename_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
